ram_ctrl: RTL and testbench

Sequencing controller upstream of the 8x8 latch-based `ram` block. Accepts single-word read/write requests over a valid/ready handshake and drives `ram`'s `inp`/`adr`/`op`/`sel` with a setup/strobe/hold sequence so address and data are stable around every select pulse. Returns read data on a registered response port. After reset it clears all eight words to 0x00 before accepting requests.

---
 rtl/ram_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ram_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// ram_ctrl: sequencing controller in front of the 8x8 latch-based ram.
// Accepts single-word requests over valid/ready and drives the ram with a
// setup / strobe / hold sequence, so address, data and op are stable for a
// full cycle on each side of every select pulse. After reset it writes 0x00
// to all eight words before it accepts any request.
module ram_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_op,
    input  logic [2:0] req_adr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       init_done,
    output logic [7:0] ram_inp,
    output logic [2:0] ram_adr,
    output logic       ram_op,
    output logic       ram_sel,
    input  logic [7:0] ram_outp
);

    typedef enum logic [2:0] {
        INIT_SETUP,
        INIT_ACCESS,
        INIT_HOLD,
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    localparam logic [2:0] LAST_ADR = 3'd7;

    state_t     state, state_d;
    logic [2:0] clr_cnt, clr_cnt_d;

    // Next values of the registered outputs.
    logic       req_ready_d;
    logic       rsp_valid_d;
    logic [7:0] rsp_data_d;
    logic       init_done_d;
    logic [7:0] ram_inp_d;
    logic [2:0] ram_adr_d;
    logic       ram_op_d;
    logic       ram_sel_d;

    logic accept;
    assign accept = req_valid && req_ready;

    // State, sweep counter and output registers; reset returns everything to idle values.
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT_SETUP;
            clr_cnt   <= 3'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            init_done <= 1'b0;
            ram_inp   <= 8'h00;
            ram_adr   <= 3'd0;
            ram_op    <= 1'b0;
            ram_sel   <= 1'b0;
        end else begin
            state     <= state_d;
            clr_cnt   <= clr_cnt_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            init_done <= init_done_d;
            ram_inp   <= ram_inp_d;
            ram_adr   <= ram_adr_d;
            ram_op    <= ram_op_d;
            ram_sel   <= ram_sel_d;
        end
    end

    // Next-state logic. The first INIT_SETUP cycle after reset still shows the
    // reset bus (ram_op=0); it loads the clear-write fields and stays put, so the
    // strobe for address 0 sees a full stable setup cycle like every other one.
    always_comb begin
        // NOTE: a default assignment before the case keeps this purely combinational (no latch).
        state_d = state;
        unique case (state)
            INIT_SETUP:  state_d = ram_op ? INIT_ACCESS : INIT_SETUP;
            INIT_ACCESS: state_d = INIT_HOLD;
            INIT_HOLD:   state_d = (clr_cnt == LAST_ADR) ? IDLE : INIT_SETUP;
            IDLE:        state_d = accept ? SETUP : IDLE;
            SETUP:       state_d = ACCESS;
            ACCESS:      state_d = HOLD;
            HOLD:        state_d = IDLE;
            default:     state_d = INIT_SETUP;
        endcase
    end

    // Output logic: computes what each output register holds in the next state.
    always_comb begin
        clr_cnt_d   = clr_cnt;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        init_done_d = init_done;
        ram_inp_d   = ram_inp;
        ram_adr_d   = ram_adr;
        ram_op_d    = ram_op;
        ram_sel_d   = 1'b0;
        unique case (state)
            INIT_SETUP: begin
                if (!ram_op) begin
                    ram_adr_d = clr_cnt;
                    ram_inp_d = 8'h00;
                    ram_op_d  = 1'b1;
                end else begin
                    ram_sel_d = 1'b1;
                end
            end
            INIT_ACCESS: begin
                ram_sel_d = 1'b0;
            end
            INIT_HOLD: begin
                if (clr_cnt == LAST_ADR) begin
                    clr_cnt_d   = 3'd0;
                    init_done_d = 1'b1;
                    req_ready_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt + 3'd1;
                    ram_adr_d = clr_cnt + 3'd1;
                    ram_inp_d = 8'h00;
                    ram_op_d  = 1'b1;
                end
            end
            IDLE: begin
                if (accept) begin
                    ram_op_d  = req_op;
                    ram_adr_d = req_adr;
                    ram_inp_d = req_data;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            SETUP: begin
                ram_sel_d = 1'b1;
            end
            ACCESS: begin
                // The ram drives outp only while selected for a read.
                if (!ram_op) begin
                    rsp_data_d  = ram_outp;
                    rsp_valid_d = 1'b1;
                end
            end
            HOLD: begin
                req_ready_d = 1'b1;
            end
            default: begin
                ram_sel_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed bench for ram_ctrl with a behavioural 8x8 ram behind it.
module tb_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [2:0] req_adr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       init_done;
    logic [7:0] ram_inp;
    logic [2:0] ram_adr;
    logic       ram_op;
    logic       ram_sel;
    wire  [7:0] ram_outp;

    int n_vec = 0;
    int n_bad = 0;

    ram_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_adr   (req_adr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .ram_inp   (ram_inp),
        .ram_adr   (ram_adr),
        .ram_op    (ram_op),
        .ram_sel   (ram_sel),
        .ram_outp  (ram_outp)
    );

    always #5 clk = ~clk;

    // Behavioural ram: starts with non-zero garbage so the clear sweep is visible.
    logic [7:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = 8'h5A + 8'(i);
    always @(posedge clk) if (ram_sel === 1'b1 && ram_op === 1'b1) mem[ram_adr] <= ram_inp;
    assign ram_outp = (ram_sel === 1'b1 && ram_op === 1'b0) ? mem[ram_adr] : 8'hzz;

    // Bus stability around each strobe: the sel cycle must match the cycle before
    // it, and the cycle after must match the sel cycle. Reset edges are exempt.
    logic [11:0] bus_q;
    logic        sel_q;
    logic        rst_q;
    always @(negedge clk) begin
        if (rst_q === 1'b0 && (ram_sel === 1'b1 || sel_q === 1'b1)) begin
            n_vec++;
            assert ({ram_adr, ram_inp, ram_op} === bus_q)
            else begin
                n_bad++;
                $error("FAIL bus_stable: observed %h expected %h", {ram_adr, ram_inp, ram_op}, bus_q);
            end
        end
        bus_q = {ram_adr, ram_inp, ram_op};
        sel_q = ram_sel;
        rst_q = rst;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_req_ready", 8'(req_ready), 8'h00);
        check("rst_rsp_valid", 8'(rsp_valid), 8'h00);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_init_done", 8'(init_done), 8'h00);
        check("rst_ram_inp", ram_inp, 8'h00);
        check("rst_ram_adr", 8'(ram_adr), 8'h00);
        check("rst_ram_op", 8'(ram_op), 8'h00);
        check("rst_ram_sel", 8'(ram_sel), 8'h00);
    endtask

    // Walks the 24-cycle clear sweep that follows reset release; cycle 25 is IDLE.
    task automatic sweep();
        for (int e = 1; e <= 24; e++) begin
            tick();
            check("sweep_adr", 8'(ram_adr), 8'((e - 1) / 3));
            check("sweep_inp", ram_inp, 8'h00);
            check("sweep_op", 8'(ram_op), 8'h01);
            check("sweep_sel", 8'(ram_sel), ((e - 1) % 3 == 1) ? 8'h01 : 8'h00);
            check("sweep_ready", 8'(req_ready), 8'h00);
            check("sweep_done", 8'(init_done), 8'h00);
            check("sweep_rsp_valid", 8'(rsp_valid), 8'h00);
        end
        tick();
        check("sweep_end_done", 8'(init_done), 8'h01);
        check("sweep_end_ready", 8'(req_ready), 8'h01);
        check("sweep_end_sel", 8'(ram_sel), 8'h00);
    endtask

    // One request from IDLE; request inputs are scrambled right after acceptance.
    // exp_rsp is the read data for a read, or the previous rsp_data for a write.
    task automatic txn(input logic op, input logic [2:0] adr, input logic [7:0] data,
                       input logic [7:0] exp_rsp);
        check("txn_ready_idle", 8'(req_ready), 8'h01);
        req_valid = 1'b1;
        req_op    = op;
        req_adr   = adr;
        req_data  = data;
        tick();
        req_valid = 1'b0;
        req_op    = ~op;
        req_adr   = ~adr;
        req_data  = ~data;
        check("setup_adr", 8'(ram_adr), 8'(adr));
        check("setup_op", 8'(ram_op), 8'(op));
        check("setup_inp", ram_inp, data);
        check("setup_sel", 8'(ram_sel), 8'h00);
        check("setup_ready", 8'(req_ready), 8'h00);
        check("setup_rsp_valid", 8'(rsp_valid), 8'h00);
        tick();
        check("access_sel", 8'(ram_sel), 8'h01);
        check("access_adr", 8'(ram_adr), 8'(adr));
        check("access_inp", ram_inp, data);
        check("access_rsp_valid", 8'(rsp_valid), 8'h00);
        tick();
        check("hold_sel", 8'(ram_sel), 8'h00);
        check("hold_adr", 8'(ram_adr), 8'(adr));
        check("hold_rsp_valid", 8'(rsp_valid), op ? 8'h00 : 8'h01);
        check("hold_rsp_data", rsp_data, exp_rsp);
        check("hold_ready", 8'(req_ready), 8'h00);
        tick();
        check("next_ready", 8'(req_ready), 8'h01);
        check("next_rsp_valid", 8'(rsp_valid), 8'h00);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_adr   = 3'd0;
        req_data  = 8'h00;
        tick();
        // A read of adr 2 is already pending while the controller comes out of reset.
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_adr   = 3'd2;
        tick();
        check_reset_vals();
        rst = 1'b0;
        sweep();

        // Pending read is accepted on the first IDLE cycle.
        tick();
        req_valid = 1'b0;
        check("early_adr", 8'(ram_adr), 8'h02);
        check("early_op", 8'(ram_op), 8'h00);
        check("early_ready", 8'(req_ready), 8'h00);
        tick();
        check("early_sel", 8'(ram_sel), 8'h01);
        tick();
        check("early_rsp_valid", 8'(rsp_valid), 8'h01);
        check("early_rsp_data", rsp_data, 8'h00);
        tick();

        // Every word reads back cleared.
        for (int k = 0; k < 8; k++) txn(1'b0, 3'(k), 8'hC3, 8'h00);

        // Write then read a single word.
        txn(1'b1, 3'd3, 8'hA5, 8'h00);
        txn(1'b0, 3'd3, 8'h00, 8'hA5);

        // Walking-one pattern; writes leave rsp_data at its last read value.
        for (int k = 0; k < 8; k++) txn(1'b1, 3'(k), 8'h01 << k, 8'hA5);

        // Back-to-back reads 7..0 with req_valid held high the whole time.
        req_valid = 1'b1;
        req_op    = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            req_adr = 3'(k);
            check("b2b_ready", 8'(req_ready), 8'h01);
            tick();
            check("b2b_adr", 8'(ram_adr), 8'(k));
            check("b2b_ready_setup", 8'(req_ready), 8'h00);
            tick();
            check("b2b_ready_access", 8'(req_ready), 8'h00);
            check("b2b_no_early_rsp", 8'(rsp_valid), 8'h00);
            tick();
            check("b2b_rsp_valid", 8'(rsp_valid), 8'h01);
            check("b2b_rsp_data", rsp_data, 8'h01 << k);
            tick();
            check("b2b_rsp_pulse", 8'(rsp_valid), 8'h00);
        end
        req_valid = 1'b0;

        // Reset lands during the strobe of a read of adr 5 (holding 0x3C).
        txn(1'b1, 3'd5, 8'h3C, 8'h01);
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_adr   = 3'd5;
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_rst_sel", 8'(ram_sel), 8'h01);
        rst = 1'b1;
        tick();
        check_reset_vals();
        rst = 1'b0;
        sweep();
        txn(1'b0, 3'd5, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
